load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute/memory pipeline stage and `data_memory` and turns RISC-V-style byte, halfword and word loads and stores into word-wide accesses on the memory's `mem_read`/`mem_write`/`addr`/`write_data`/`read_data` port. Loads are sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because `data_memory` only writes whole words. Misaligned and illegal requests are rejected with an error response and never touch memory.

## Interface
- `ADDR_W`, 32: byte-address width; data width is fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit accepts a request; high only in IDLE and only while `rst` is low.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU and HU are loads only).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for B and H.
- `resp_valid` out 1: response present; held until accepted.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal request.
- `mem_read` out 1: to `data_memory.mem_read`.
- `mem_write` out 1: to `data_memory.mem_write`.
- `mem_addr` out ADDR_W: to `data_memory.addr`; always word-aligned, i.e. `{addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata` out 32: to `data_memory.write_data`.
- `mem_rdata` in 32: from `data_memory.read_data`; combinational while `mem_read`=1.

## Operation
- States: IDLE, READ, WRITE, RESP.
- On `req_valid & req_ready`, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- Illegal requests go to RESP with `resp_err`=1. Illegal means a funct3 outside the list, or a store with funct3[2]=1.
- Misaligned requests go to RESP with `resp_err`=1. Misaligned means H/HU with addr[0]≠0, or W with addr[1:0]≠0.
- Legal load: IDLE→READ→RESP.
- Legal SW: IDLE→WRITE→RESP; `mem_wdata` = latched data.
- Legal SB/SH: IDLE→READ→WRITE→RESP. The word read in READ is merged with the store data, and the merged word is written in WRITE.
- READ: `mem_read`=1. `mem_rdata` is captured into the word register at the end of the cycle.
- WRITE: `mem_write`=1. `data_memory` commits the word on the rising edge that ends this cycle.
- RESP: `resp_valid`=1. On `resp_ready` go to IDLE; otherwise hold all response outputs stable.
- Byte lanes are little-endian; the lane is selected by addr[1:0] (B) or addr[1] (H).
  - Load extraction: B/H sign-extend from bit 7/15; BU/HU zero-extend.
  - Store merge: replace only the selected lane(s) of the captured word.
- `mem_read` and `mem_write` are never high in the same cycle.
- `mem_addr` and `mem_wdata` are 0 whenever both strobes are low.

## Timing
- Request accepted at edge E0. `resp_valid` rises after:
  - LW, LB, LH, LBU, LHU: E2.
  - SW: E2.
  - SB, SH: E3.
  - error: E1.
- Throughput is one request in flight. `req_ready` is 0 from E0 until the cycle after the response handshake.
- A response handshake and a new request cannot occur in the same cycle.
- Reset values while `rst`=1 and on the first cycle after: state IDLE, all other outputs 0.
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`: 0.
  - `resp_valid`, `resp_data`, `resp_err`: 0.
  - `req_ready`: 0 while `rst`=1, 1 after.
- Reset mid-operation aborts the access. `mem_write` is gated by `!rst`, so a write scheduled in the reset cycle does not occur. The pending response is discarded.
- `resp_ready` held high before `resp_valid` completes the handshake in the first RESP cycle.

## Structure
- `lsu_pkg`: funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum `lsu_state_t`. Shared with the decoder.
- Sub-module `load_store_align`, purely combinational:
  - `misaligned`/`illegal` check;
  - load extract + extend;
  - store merge.
- The top level holds the FSM, request latches and captured word.

## Test plan
- After reset, memory preloaded with 0x8899AABB at 0x10. LB at 0x11 → `resp_data`=0xFFFFFFAA, `resp_valid` at E2. LBU at 0x11 → 0x000000AA. LH at 0x12 → 0xFFFF8899. LW at 0x10 → 0x8899AABB.
- Memory word 0x11223344 at 0x20:
  - SB 0x55 at 0x22 → one read, then one write of 0x11553344; response at E3, `resp_err`=0.
  - SH 0xBEEF at 0x20 → word becomes 0x1155BEEF.
- SW 0xDEADBEEF at 0x08 → no `mem_read` pulse, write at E1, response at E2. A following LW at 0x08 returns 0xDEADBEEF.
- Error cases: LW at 0x06, SH at 0x03, and funct3=011 → `resp_err`=1, `resp_data`=0 at E1. `mem_read`/`mem_write` stay 0 throughout.
- Response backpressure: hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_data` and `req_ready`=0 stay stable; release → IDLE next cycle.
- Reset mid-operation: assert `rst` during WRITE of an SB to 0x30 holding 0xCAFEF00D → no write occurs, the word stays 0xCAFEF00D, and all outputs are 0 the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store encodings and FSM state type for the load/store unit and the decoder.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational request checking, little-endian load extraction/extension and
// sub-word store merge into a full memory word.
module load_store_align
    import lsu_pkg::*;
(
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic              misaligned,
    output logic              illegal,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [4:0]        sh_b;
    logic [4:0]        sh_h;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] mask;

    always_comb begin
        sh_b       = {addr_lo, 3'b000};
        sh_h       = {addr_lo[1], 4'b0000};
        lane_b     = 8'(word >> sh_b);
        lane_h     = 16'(word >> sh_h);
        misaligned = 1'b0;
        illegal    = 1'b0;
        load_data  = '0;
        mask       = '0;
        store_word = wdata;
        case (funct3)
            F3_B: begin
                load_data  = {{24{lane_b[7]}}, lane_b};
                mask       = DATA_W'(32'h0000_00FF) << sh_b;
                store_word = (word & ~mask) | (DATA_W'(wdata[7:0]) << sh_b);
            end
            F3_H: begin
                misaligned = addr_lo[0];
                load_data  = {{16{lane_h[15]}}, lane_h};
                mask       = DATA_W'(32'h0000_FFFF) << sh_h;
                store_word = (word & ~mask) | (DATA_W'(wdata[15:0]) << sh_h);
            end
            F3_W: begin
                misaligned = (addr_lo != 2'b00);
                load_data  = word;
            end
            F3_BU: begin
                illegal   = we;
                load_data = {24'b0, lane_b};
            end
            F3_HU: begin
                illegal    = we;
                misaligned = addr_lo[0];
                load_data  = {16'b0, lane_h};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into word-wide data_memory
// accesses, using read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              pend_q, pend_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic              misaligned;
    logic              illegal;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic [ADDR_W-1:0] word_addr;

    load_store_align u_align (
        .we         (we_q),
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .misaligned (misaligned),
        .illegal    (illegal),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign req_ready = (state_q == ST_IDLE) && !pend_q && !rst;
    assign accept    = req_valid && req_ready;

    // A latched request is decoded in the cycle after acceptance (pend_q), so all
    // strobes and response fields below come straight from flops.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (misaligned || illegal) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else if (!we_q || (f3_q != F3_W)) begin
                        state_d    = ST_READ;
                        mem_read_d = 1'b1;
                        mem_addr_d = word_addr;
                    end else begin
                        state_d     = ST_WRITE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = word_addr;
                        mem_wdata_d = wdata_q;
                    end
                end else if (accept) begin
                    pend_d = 1'b1;
                end
            end
            ST_READ: begin
                if (we_q) begin
                    state_d     = ST_WRITE;
                    mem_write_d = 1'b1;
                    mem_addr_d  = word_addr;
                    mem_wdata_d = store_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = load_data;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = '0;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_data_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= 1'b0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Reset blanks every output in its own cycle so a scheduled write cannot commit.
    assign mem_read   = mem_read_q && !rst;
    assign mem_write  = mem_write_q && !rst;
    assign mem_addr   = rst ? '0 : mem_addr_q;
    assign mem_wdata  = rst ? '0 : mem_wdata_q;
    assign resp_valid = resp_valid_q && !rst;
    assign resp_data  = rst ? '0 : resp_data_q;
    assign resp_err   = resp_err_q && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model plus a byte-level
// reference model of loads/stores, directed cases then random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [31:0] mem [64];
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;
    logic [7:0]  ref_bytes [256];

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: combinational read, whole-word write on the rising edge
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[7:2]] <= pl_data;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        rd_cnt += int'(mem_read);
        wr_cnt += int'(mem_write);
        chkb("strobe_exclusive", mem_read & mem_write, 1'b0);
        if (!mem_read && !mem_write) begin
            chk("idle_mem_addr", mem_addr, 32'h0);
            chk("idle_mem_wdata", mem_wdata, 32'h0);
        end else begin
            chk("mem_addr_aligned", 32'(mem_addr[1:0]), 32'h0);
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_bytes[b + 8'd3], ref_bytes[b + 8'd2], ref_bytes[b + 8'd1], ref_bytes[b]};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        for (int i = 0; i < 4; i++) ref_bytes[8'({a[7:2], 2'b00} + 32'(i))] = 8'(d >> (8 * i));
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Reference: RISC-V byte-addressed semantics on a flat byte array
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] data,
                         output int n);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        n = 0;
        endcase
        err = (n == 0) || (we && f3[2]);
        if (!err && (int'(a) % n) != 0) err = 1'b1;
        v = 32'h0;
        data = 32'h0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (we) ref_bytes[8'(a + 32'(i))] = 8'(wd >> (8 * i));
                else    v |= 32'(ref_bytes[8'(a + 32'(i))]) << (8 * i);
            end
            if (!we) begin
                if (!f3[2] && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
                data = v;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        logic        exp_err;
        logic [31:0] exp_data;
        int          n, lat, wr_lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
        model(we, f3, a, wd, exp_err, exp_data, n);
        exp_lat = exp_err ? 1 : ((we && n < 4) ? 3 : 2);
        exp_rd  = (exp_err || (we && n == 4)) ? 0 : 1;
        exp_wr  = (!exp_err && we) ? 1 : 0;
        @(negedge clk);
        chkb("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = (hold == 0);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chkb("req_ready_busy", req_ready, 1'b0);
        lat = 0; wr_lat = -1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (mem_write) wr_lat = lat;
        end
        chk("resp_latency", 32'(lat), 32'(exp_lat));
        chkb("resp_err", resp_err, exp_err);
        chk("resp_data", resp_data, exp_data);
        chkb("req_ready_resp", req_ready, 1'b0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chkb("hold_resp_valid", resp_valid, 1'b1);
                chk("hold_resp_data", resp_data, exp_data);
                chkb("hold_resp_err", resp_err, exp_err);
                chkb("hold_req_ready", req_ready, 1'b0);
            end
            @(negedge clk);
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chkb("post_resp_valid", resp_valid, 1'b0);
        chkb("post_req_ready", req_ready, 1'b1);
        chk("post_resp_data", resp_data, 32'h0);
        chk("mem_read_pulses", 32'(rd_cnt - rd0), 32'(exp_rd));
        chk("mem_write_pulses", 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_wr == 1) chk("write_cycle", 32'(wr_lat), (n == 4) ? 32'd1 : 32'd2);
        chk("mem_word", mem[a[7:2]], ref_word(a));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chkb({tag, "_mem_read"}, mem_read, 1'b0);
        chkb({tag, "_mem_write"}, mem_write, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chkb({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_data"}, resp_data, 32'h0);
        chkb({tag, "_resp_err"}, resp_err, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        pl_en = 1'b0; pl_addr = 32'h0; pl_data = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("in_reset");
        chkb("in_reset_req_ready", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_outputs_zero("after_reset");
        chkb("after_reset_req_ready", req_ready, 1'b1);

        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);

        preload(32'h10, 32'h8899_AABB);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);

        preload(32'h20, 32'h1122_3344);
        do_req(1'b1, 3'b000, 32'h22, 32'h0000_0055, 0);
        chk("sb_word", mem[8], 32'h1155_3344);
        do_req(1'b1, 3'b001, 32'h20, 32'h0000_BEEF, 0);
        chk("sh_word", mem[8], 32'h1155_BEEF);

        do_req(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'b010, 32'h08, 32'h0, 0);
        chk("sw_word", mem[2], 32'hDEAD_BEEF);

        do_req(1'b0, 3'b010, 32'h06, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h03, 32'h1234_5678, 0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 0);

        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5);

        // reset during the WRITE cycle of a read-modify-write byte store
        preload(32'h30, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h30; req_wdata = 32'h0000_0012; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chkb("rmw_read_strobe", mem_read, 1'b1);
        @(posedge clk); #1;
        chkb("rmw_write_strobe", mem_write, 1'b1);
        chk("rmw_merged_word", mem_wdata, 32'hCAFE_F012);
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        chkb("mid_reset_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_outputs_zero("post_abort");
        chkb("post_abort_req_ready", req_ready, 1'b1);
        chk("aborted_word", mem[12], 32'hCAFE_F00D);
        resp_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
